// File: rtl/motor_pwm_driver.sv
// motor_pwm_driver: H-bridge PWM stage fed by the position ON/OFF controller (duty magnitude + direction).
// Latency: legs are registered one clock behind pwm_cnt; duty, direction and state change only at period boundaries.
// Backpressure: none; targets are sampled at period boundaries and ignored in between.
//
// Ports:
//   clock_control    system clock, rising edge
//   reset_n          asynchronous active-low reset (drops both legs immediately)
//   Senial_control   target duty 0..255
//   Dir              target direction (0 -> PWM_A leg, 1 -> PWM_B leg)
//   PWM_A / PWM_B    forward / reverse legs, registered, never high together
//   Dir_actual       direction currently applied
//   Duty_actual      duty currently applied
//   Periodo          one-clock pulse on each period boundary
//   Busy             high while a reversal is in progress (ramp-down or dead time)
//
// Build option: define MOTOR_RAMP_EN to slew duty by RAMP_STEP per period in RUN and
// REVERSE; without it RUN jumps straight to the target and reversals go directly to
// dead time with the duty forced to 0.
module motor_pwm_driver #(
  parameter int PRESCALE     = 4,  // clocks per PWM tick
  parameter int RAMP_STEP    = 8,  // duty change per period when ramping
  parameter int DEAD_PERIODS = 2   // full periods with both legs low on a reversal
) (
  input  logic       clock_control,
  input  logic       reset_n,
  input  logic [7:0] Senial_control,
  input  logic       Dir,
  output logic       PWM_A,
  output logic       PWM_B,
  output logic       Dir_actual,
  output logic [7:0] Duty_actual,
  output logic       Periodo,
  output logic       Busy
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DW = $clog2(DEAD_PERIODS + 1);

  // Elaboration-time guard against parameter values the timebase and ramp cannot honour.
  if (PRESCALE < 1 || RAMP_STEP < 1 || RAMP_STEP > 255 || DEAD_PERIODS < 1) begin : g_param_check
    $error("motor_pwm_driver: illegal parameter value");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_REVERSE,
    S_DEAD
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [7:0]      duty_q, duty_d;
  logic            dir_q, dir_d;
  logic [DW-1:0]   dead_q, dead_d;
  logic            pwm_a_q, pwm_a_d;
  logic            pwm_b_q, pwm_b_d;

  logic            tick;
  logic            boundary;
  logic            drive_en;
  logic            pwm;

  // ---------------------------------------------------------------------------
  // Timebase: prescaler 0..PRESCALE-1, pwm_cnt 0..254 (255 steps so duty 255 is
  // constantly high and duty 0 constantly low).
  // ---------------------------------------------------------------------------
  assign tick     = (presc_q == PW'(PRESCALE - 1));
  assign boundary = tick && (cnt_q == 8'd254);

  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
    cnt_d   = cnt_q;
    if (tick) begin
      cnt_d = (cnt_q == 8'd254) ? 8'd0 : cnt_q + 8'd1;
    end
  end

`ifdef MOTOR_RAMP_EN
  // One slew step from cur toward tgt, computed at 9 bits so the sum cannot wrap
  // past 255 and the difference cannot go below the target.
  function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
    logic [8:0] up;
    logic [8:0] gap;
    up  = {1'b0, cur} + 9'(RAMP_STEP);
    gap = {1'b0, cur} - {1'b0, tgt};
    if (tgt > cur) begin
      step_toward = (up > {1'b0, tgt}) ? tgt : up[7:0];
    end else if (gap <= 9'(RAMP_STEP)) begin
      step_toward = tgt;
    end else begin
      step_toward = cur - 8'(RAMP_STEP);
    end
  endfunction

  logic [7:0] run_next;
  logic [7:0] rev_next;
  assign run_next = step_toward(duty_q, Senial_control);
  assign rev_next = step_toward(duty_q, 8'd0);
`endif

  // ---------------------------------------------------------------------------
  // Drive state machine: evaluated only at a period boundary so every new duty
  // and direction starts cleanly at pwm_cnt = 0.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    dir_d   = dir_q;
    dead_d  = dead_q;
    if (boundary) begin
      case (state_q)
        S_IDLE: begin
          duty_d = 8'd0;
          if (Senial_control != 8'd0) begin
            dir_d   = Dir;
            state_d = S_RUN;
`ifdef MOTOR_RAMP_EN
            duty_d  = run_next;  // duty_q is 0 here, so this is the first step up
`else
            duty_d  = Senial_control;
`endif
          end
        end
        S_RUN: begin
          // A zero target never reverses: that is the controller's deadband.
          if (Senial_control != 8'd0 && Dir != dir_q) begin
`ifdef MOTOR_RAMP_EN
            state_d = S_REVERSE;
`else
            state_d = S_DEAD;
            duty_d  = 8'd0;
            dead_d  = DW'(DEAD_PERIODS);
`endif
          end else if (Senial_control == 8'd0 && duty_q == 8'd0) begin
            state_d = S_IDLE;
          end else begin
`ifdef MOTOR_RAMP_EN
            duty_d = run_next;
`else
            duty_d = Senial_control;
`endif
          end
        end
        S_REVERSE: begin
          // Inputs are ignored: the ramp-down always completes once started.
`ifdef MOTOR_RAMP_EN
          duty_d = rev_next;
          if (rev_next == 8'd0) begin
            state_d = S_DEAD;
            dead_d  = DW'(DEAD_PERIODS);
          end
`else
          duty_d  = 8'd0;
          state_d = S_DEAD;
          dead_d  = DW'(DEAD_PERIODS);
`endif
        end
        S_DEAD: begin
          dead_d = dead_q - DW'(1);
          if (dead_q == DW'(1)) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          duty_d  = 8'd0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Leg outputs: only one leg can ever be enabled because both are gated by the
  // single applied direction bit; DEAD and IDLE force both low.
  // ---------------------------------------------------------------------------
  assign pwm      = (cnt_q < duty_q);
  assign drive_en = (state_q == S_RUN) || (state_q == S_REVERSE);
  assign pwm_a_d  = pwm && !dir_q && drive_en;
  assign pwm_b_d  = pwm &&  dir_q && drive_en;

  always_ff @(posedge clock_control or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      cnt_q   <= 8'd0;
      duty_q  <= 8'd0;
      dir_q   <= 1'b0;
      dead_q  <= '0;
      pwm_a_q <= 1'b0;
      pwm_b_q <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      dir_q   <= dir_d;
      dead_q  <= dead_d;
      pwm_a_q <= pwm_a_d;
      pwm_b_q <= pwm_b_d;
    end
  end

  assign PWM_A       = pwm_a_q;
  assign PWM_B       = pwm_b_q;
  assign Dir_actual  = dir_q;
  assign Duty_actual = duty_q;
  assign Periodo     = boundary;
  assign Busy        = (state_q == S_REVERSE) || (state_q == S_DEAD);

endmodule

// File: tb/tb_motor_pwm_driver.sv
// tb_motor_pwm_driver: checks motor_pwm_driver against a period-level behavioural model.
// Latency: compares every clock on the falling edge; directed table plus hand sequences plus random targets.
// Backpressure: not applicable; all waits on the DUT are bounded.
module tb_motor_pwm_driver;

  localparam int P   = 2;
  localparam int RS  = 8;
  localparam int DP  = 2;
  localparam int PER = 255 * P;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_REV  = 2;
  localparam int M_DEAD = 3;

  logic       clock_control = 1'b0;
  logic       reset_n;
  logic [7:0] Senial_control;
  logic       Dir;
  logic       PWM_A, PWM_B, Dir_actual, Periodo, Busy;
  logic [7:0] Duty_actual;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  motor_pwm_driver #(.PRESCALE(P), .RAMP_STEP(RS), .DEAD_PERIODS(DP)) dut (
    .clock_control (clock_control),
    .reset_n       (reset_n),
    .Senial_control(Senial_control),
    .Dir           (Dir),
    .PWM_A         (PWM_A),
    .PWM_B         (PWM_B),
    .Dir_actual    (Dir_actual),
    .Duty_actual   (Duty_actual),
    .Periodo       (Periodo),
    .Busy          (Busy)
  );

  always #5 clock_control = ~clock_control;

  // ---------------- behavioural reference model ----------------
  typedef struct {
    int c;      // clocks elapsed within the current period
    int mode;
    int duty;
    bit dir;
    int dead;
    bit pa;
    bit pb;
  } mstate_t;

  mstate_t m;

  function automatic int toward(int cur, int tgt);
`ifdef MOTOR_RAMP_EN
    if (tgt > cur) return (cur + RS > tgt) ? tgt : cur + RS;
    return (cur - RS < tgt) ? tgt : cur - RS;
`else
    return tgt + 0 * cur;
`endif
  endfunction

  function automatic mstate_t step(mstate_t s, int sen, bit d);
    mstate_t n;
    int      cnt;
    bit      act;
    n   = s;
    cnt = s.c / P;
    act = (s.mode == M_RUN) || (s.mode == M_REV);
    n.pa = (cnt < s.duty) && !s.dir && act;
    n.pb = (cnt < s.duty) &&  s.dir && act;
    n.c  = (s.c + 1) % PER;
    if (s.c == PER - 1) begin
      case (s.mode)
        M_IDLE: if (sen > 0) begin n.dir = d; n.mode = M_RUN; n.duty = toward(0, sen); end
        M_RUN: begin
          if (sen > 0 && d != s.dir) begin
`ifdef MOTOR_RAMP_EN
            n.mode = M_REV;
`else
            n.mode = M_DEAD; n.duty = 0; n.dead = DP;
`endif
          end else if (sen == 0 && s.duty == 0) n.mode = M_IDLE;
          else n.duty = toward(s.duty, sen);
        end
        M_REV: begin
          n.duty = toward(s.duty, 0);
          if (n.duty == 0) begin n.mode = M_DEAD; n.dead = DP; end
        end
        default: begin
          n.dead = s.dead - 1;
          if (n.dead == 0) n.mode = M_IDLE;
        end
      endcase
    end
    return n;
  endfunction

  always @(posedge clock_control or negedge reset_n) begin
    if (!reset_n) m <= '{default: 0};
    else          m <= step(m, int'(Senial_control), Dir);
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clock_control) begin
    if (chk_en) begin
      logic [13:0] got, exp;
      got = {PWM_A, PWM_B, Dir_actual, Duty_actual, Periodo, Busy};
      exp = {m.pa, m.pb, m.dir, 8'(m.duty), (m.c == PER - 1), (m.mode == M_REV || m.mode == M_DEAD)};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL model t=%0t A/B/dir/duty/per/busy got %b/%b/%b/%0d/%b/%b want %b/%b/%b/%0d/%b/%b",
                 $time, got[13], got[12], got[11], got[10:3], got[2], got[1],
                 exp[13], exp[12], exp[11], exp[10:3], exp[2], exp[1]);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // Called at a falling edge; returns at the falling edge just after the next boundary update.
  task automatic wait_bnd();
    int k = 0;
    while (Periodo !== 1'b1 && k < PER + 10) begin @(negedge clock_control); k++; end
    if (Periodo !== 1'b1) check("boundary_timeout", 0, 1);
    @(negedge clock_control);
  endtask

  task automatic settle(input int tgt);
    int k = 0;
    do begin wait_bnd(); k++; end while (int'(Duty_actual) != tgt && k < 60);
    check("settle_duty", int'(Duty_actual), tgt);
  endtask

  task automatic count_legs(input int n, output int a, output int b);
    a = 0; b = 0;
    repeat (n) begin
      @(negedge clock_control);
      a += int'(PWM_A);
      b += int'(PWM_B);
    end
  endtask

  typedef struct {
    int sen;
    bit dir;
    int nb;
    int duty;
    bit dira;
    bit busy;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int a, b, busy_hi, leg_hi, k;

    // ---------------- vector table ----------------
`ifdef MOTOR_RAMP_EN
    for (int i = 0; i < 16; i++) tbl.push_back('{128, 1'b0, 1, 8 * (i + 1), 1'b0, 1'b0});
    tbl.push_back('{128, 1'b0, 1, 128, 1'b0, 1'b0});
    tbl.push_back('{128, 1'b1, 1, 128, 1'b0, 1'b1});
    tbl.push_back('{128, 1'b0, 1, 120, 1'b0, 1'b1});
`else
    tbl.push_back('{128, 1'b0, 1, 128, 1'b0, 1'b0});
    tbl.push_back('{200, 1'b0, 1, 200, 1'b0, 1'b0});
    tbl.push_back('{200, 1'b1, 1,   0, 1'b0, 1'b1});
    tbl.push_back('{200, 1'b1, 1,   0, 1'b0, 1'b1});
    tbl.push_back('{200, 1'b1, 1,   0, 1'b0, 1'b0});
    tbl.push_back('{200, 1'b1, 1, 200, 1'b1, 1'b0});
    tbl.push_back('{  0, 1'b1, 1,   0, 1'b1, 1'b0});
    tbl.push_back('{  0, 1'b0, 1,   0, 1'b1, 1'b0});
    tbl.push_back('{  0, 1'b1, 2,   0, 1'b1, 1'b0});
    tbl.push_back('{255, 1'b0, 1, 255, 1'b0, 1'b0});
    tbl.push_back('{  1, 1'b0, 1,   1, 1'b0, 1'b0});
`endif

    // ---------------- reset state ----------------
    reset_n        = 1'b0;
    Senial_control = 8'd0;
    Dir            = 1'b0;
    repeat (3) @(negedge clock_control);
    check("reset_outputs", int'({PWM_A, PWM_B, Dir_actual, Duty_actual, Periodo, Busy}), 0);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    foreach (tbl[i]) begin
      Senial_control = 8'(tbl[i].sen);
      Dir            = tbl[i].dir;
      repeat (tbl[i].nb) wait_bnd();
      vectors++;
      if ({Duty_actual, Dir_actual, Busy} !== {8'(tbl[i].duty), tbl[i].dira, tbl[i].busy}) begin
        miscompares++;
        $display("FAIL table[%0d] duty/dir/busy got %0d/%b/%b want %0d/%b/%b", i,
                 Duty_actual, Dir_actual, Busy, tbl[i].duty, tbl[i].dira, tbl[i].busy);
      end
    end

    // ---------------- steady drive at 128, forward ----------------
    Senial_control = 8'd128;
    Dir            = 1'b0;
    settle(128);
    count_legs(PER, a, b);
    check("duty128_A_high_clocks", a, 128 * P);
    check("duty128_B_high_clocks", b, 0);

    // ---------------- full duty ----------------
    Senial_control = 8'd255;
    settle(255);
    count_legs(PER, a, b);
    check("duty255_A_high_clocks", a, PER);

    // ---------------- zero target with Dir toggling stays idle ----------------
    Senial_control = 8'd0;
    settle(0);
    wait_bnd();
    busy_hi = 0; leg_hi = 0;
    for (int t = 0; t < 3 * PER; t++) begin
      if (t % 100 == 0) Dir = ~Dir;
      @(negedge clock_control);
      busy_hi += int'(Busy);
      leg_hi  += int'(PWM_A) + int'(PWM_B);
    end
    check("deadband_busy_clocks", busy_hi, 0);
    check("deadband_leg_clocks", leg_hi, 0);

    // ---------------- asynchronous reset mid-period ----------------
    Dir            = 1'b0;
    Senial_control = 8'd200;
    settle(200);
    repeat (40 * P) @(negedge clock_control);
    check("pre_reset_A", int'(PWM_A), 1);
    #1 reset_n = 1'b0;
    #1 check("async_reset_legs", int'({PWM_A, PWM_B}), 0);
    repeat (2) @(negedge clock_control);
    reset_n = 1'b1;
    check("post_reset_duty_busy_dir", int'({Duty_actual, Busy, Dir_actual}), 0);
    leg_hi = 0; k = 0;
    while (Periodo !== 1'b1 && k < PER + 10) begin
      @(negedge clock_control);
      leg_hi += int'(PWM_A) + int'(PWM_B);
      k++;
    end
    check("post_reset_first_period_legs", leg_hi, 0);
    @(negedge clock_control);
    count_legs(PER, a, b);
    check("post_reset_resume_A", a, P * toward(0, 200));

    // ---------------- random targets ----------------
    for (int it = 0; it < 30; it++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 2)       Senial_control = 8'd0;
      else if (r == 2) Senial_control = 8'd255;
      else             Senial_control = 8'($urandom_range(1, 254));
      Dir = 1'($urandom_range(0, 1));
      repeat ($urandom_range(20, 700)) @(negedge clock_control);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/motor_pwm_driver.md
Name: motor_pwm_driver

Overview:
- Downstream stage of the position ON/OFF controller. Consumes its 8-bit `Senial_control` magnitude and `Dir` bit and drives an H-bridge through two PWM legs.
- Latches duty and direction only at PWM period boundaries. Optionally slews duty, and enforces ramp-down plus dead time on every direction reversal, so both legs are never active together.

Parameters:
- PRESCALE, 4: clock cycles per PWM tick (≥1).
- RAMP_STEP, 8: duty change per period when ramping (1..255).
- DEAD_PERIODS, 2: full PWM periods with both legs low during a reversal (≥1).

Ports:
- clock_control  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- Senial_control  in  8  target duty (0..255).
- Dir  in  1  target direction; 0 drives PWM_A, 1 drives PWM_B.
- PWM_A  out  1  forward leg, registered.
- PWM_B  out  1  reverse leg, registered.
- Dir_actual  out  1  direction currently applied.
- Duty_actual  out  8  duty currently applied.
- Periodo  out  1  one-clock pulse on each period boundary.
- Busy  out  1  high in REVERSE or DEAD.

Behaviour:
- Reset (async assert, sync release):
  - PWM_A, PWM_B, Dir_actual, Duty_actual, Periodo, Busy all 0.
  - Prescaler and pwm_cnt 0; state IDLE.
  - Asserting reset mid-period drops PWM_A and PWM_B immediately, without waiting for a clock.
- Timebase:
  - Prescaler counts 0..PRESCALE-1; tick when it is at PRESCALE-1.
  - pwm_cnt counts 0..254 on ticks and wraps to 0. Period = 255*PRESCALE clocks.
  - Boundary = the tick cycle with pwm_cnt==254. Periodo=1 on that cycle.
  - All state, duty and direction updates happen only at a boundary. New values apply from pwm_cnt=0.
- Output:
  - pwm = (pwm_cnt < Duty_actual). Duty 0 gives constant low; duty 255 gives constant high.
  - PWM_A <= pwm & ~Dir_actual & (state==RUN or REVERSE).
  - PWM_B <= pwm & Dir_actual & (same states).
  - Outputs are registered, so they lag pwm_cnt by one clock. PWM_A&PWM_B is never 1.
- States (evaluated at a boundary):
  - IDLE: Duty_actual=0. If Senial_control>0: Dir_actual<=Dir, go to RUN, apply the first duty step.
  - RUN, reversal: if Senial_control>0 and Dir!=Dir_actual, go to REVERSE.
  - RUN, stop: else if Senial_control==0 and Duty_actual==0, go to IDLE.
  - RUN, otherwise: Duty_actual steps toward Senial_control.
  - REVERSE: Duty_actual steps toward 0. When it reaches 0, go to DEAD and load the dead counter with DEAD_PERIODS.
  - REVERSE ignores the inputs: a Dir flip-back or target change does not abort ramp-down.
  - DEAD: both legs low. The counter decrements each boundary; at 1→0 go to IDLE.
  - IDLE is therefore one period with zero duty before the new direction is applied.
- Direction with zero target: a Dir change while Senial_control==0 never triggers a reversal. This is the controller's deadband (Senial 0, Dir 0).
- Ramp arithmetic:
  - Computed at 9 bits.
  - Up: min(target, duty+RAMP_STEP). Down: max(target, duty-RAMP_STEP).
  - Never overflows past 255 and never underflows below 0 or the target.
- Inputs are sampled only at boundaries. Changes between boundaries are ignored.

Optional Feature:
- Macro: MOTOR_RAMP_EN.
- Defined: slew limiting as above, in both RUN and REVERSE.
- Undefined:
  - RUN loads Duty_actual=Senial_control directly at each boundary.
  - A reversal detected in RUN goes straight to DEAD with Duty_actual=0 at that boundary. REVERSE is unreachable.
  - RAMP_STEP is unused.

Test Plan:
- Steady drive, ramp off, PRESCALE=1. Reset, then Senial=128, Dir=0 → from the first boundary, PWM_A high 128 of every 255 clocks; PWM_B always 0; Duty_actual=128.
- Ramp on, RAMP_STEP=8. Senial 0→128, Dir=0 → Duty_actual 8,16,…,128 over 16 boundaries, then holds at 128.
- Reversal, ramp on. Running at 64 with Dir=0, set Dir=1 → Busy=1. Duty 56..0 over 8 periods, then 2 DEAD periods with both legs low, 1 IDLE period, then RUN with Dir_actual=1 and PWM_B at duty 8. No cycle with both legs high.
- Extremes: Senial=255 → PWM_A constantly 1. Senial=0 with Dir toggling every 100 clocks → state stays IDLE, both legs 0, Busy 0.
- Reset mid-operation: drop reset_n at pwm_cnt=40 while running at duty 200 → PWM_A=0 asynchronously. After release, Duty_actual=0, state IDLE, and PWM resumes only after the next boundary.
